// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types for the fetch/data memory port arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   function automatic arb_owner_t other_owner(input arb_owner_t owner);
      return (owner == OWN_I) ? OWN_D : OWN_I;
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : combinational two-way picker between fetch and data requests
// Revision : 1.0
// ============================================================================
module rr_pick2
   import mem_arb_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic       fetch_req_i,
   input  logic       data_req_i,
   input  arb_owner_t last_owner_i,
   output logic       grant_valid_o,
   output arb_owner_t grant_o
);

   always_comb begin
      grant_valid_o = fetch_req_i | data_req_i;
      grant_o       = OWN_D;
      if (fetch_req_i && data_req_i) begin
         // Without round robin the data port keeps priority on contention
         if (ROUND_ROBIN != 0) begin
            grant_o = other_owner(last_owner_i);
         end
      end else if (fetch_req_i) begin
         grant_o = OWN_I;
      end
   end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one single-ported memory between fetch and data
//                    ports, one outstanding transaction, with a watchdog
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int ROUND_ROBIN    = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic                  i_ack,
   output logic [DATA_W-1:0]     i_rdata,
   output logic                  i_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wstrb,
   output logic                  d_ack,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int              STRB_W  = DATA_W / 8;
   localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_t          state_q, state_d;
   arb_owner_t          owner_q, owner_d;
   arb_owner_t          last_owner_q, last_owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;

   logic                w_grant_valid;
   arb_owner_t          w_grant;
   logic                w_wd_expired;
   logic                w_done;
   logic                w_err;
   logic                w_ack;
   logic                w_issue;

   rr_pick2 #(
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_pick (
      .fetch_req_i   (i_req),
      .data_req_i    (d_req),
      .last_owner_i  (last_owner_q),
      .grant_valid_o (w_grant_valid),
      .grant_o       (w_grant)
   );

   assign w_wd_expired = WD_EN && (wd_cnt_q == WD_LAST);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      wd_cnt_d     = wd_cnt_q;
      w_done       = 1'b0;
      w_err        = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (w_grant_valid) begin
               state_d      = ARB_ISSUE;
               owner_d      = w_grant;
               last_owner_d = w_grant;
               wd_cnt_d     = '0;
               if (w_grant == OWN_D) begin
                  we_d    = d_we;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  wstrb_d = d_we ? d_wstrb : '1;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = i_addr;
                  wdata_d = '0;
                  wstrb_d = '1;
               end
            end
         end

         ARB_ISSUE: begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            if (w_wd_expired) begin
               w_done  = 1'b1;
               w_err   = 1'b1;
               state_d = ARB_IDLE;
            end else if (mem_ready) begin
               state_d = ARB_WAIT;
            end
         end

         ARB_WAIT: begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            // A response landing on the expiry cycle still counts as success
            if (mem_rvalid) begin
               w_done  = 1'b1;
               state_d = ARB_IDLE;
            end else if (w_wd_expired) begin
               w_done  = 1'b1;
               w_err   = 1'b1;
               state_d = ARB_IDLE;
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWN_I;
         last_owner_q <= OWN_I;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   // Outputs are masked during reset so an in-flight transaction is dropped silently
   assign w_issue = (state_q == ARB_ISSUE) && !rst;
   assign w_ack   = w_done && !rst;

   assign i_ack   = w_ack && (owner_q == OWN_I);
   assign i_err   = i_ack && w_err;
   assign i_rdata = (i_ack && !w_err) ? mem_rdata : '0;

   assign d_ack   = w_ack && (owner_q == OWN_D);
   assign d_err   = d_ack && w_err;
   assign d_rdata = (d_ack && !w_err) ? mem_rdata : '0;

   assign mem_req   = w_issue;
   assign mem_we    = w_issue && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = w_issue ? wstrb_q : '0;

endmodule : mem_port_arbiter
`default_nettype wire
